sd_adma_desc_sched: RTL and testbench
=====================================

// Module: sd_adma_desc_sched
// PURPOSE
//  Descriptor scheduler for the SD host DMA path. Walks the ADMA2-style descriptor table
//  (NOP/RSV/TRAN/LINK) through a 1-cycle-latency read port and hands one transfer at a
//  time to DMA/DATA. Each transfer ends on transfer_complete. Sits between the register
//  block (start/stop) and DMA; owns the descriptor index that SD_host currently registers.
// PARAMETERS
//  DESC_W    86  descriptor width: [85:22] addr, [20:5] len, [4] act1, [3] act2, [2] end, [1] valid, [0] dir
//  IDX_W     6   descriptor index width; table depth 2**IDX_W
//  MAX_LINK  64  LINK hops per run before a loop error
// PORTS
//  clk_host       in   1       host clock, all logic on rising edge
//  reset_host     in   1       asynchronous, active-high reset
//  start          in   1       pulse: begin run at start_idx; ignored while busy
//  start_idx      in   IDX_W   first descriptor index
//  stop_req       in   1       abort current run
//  desc_rd_en     out  1       table read strobe
//  desc_rd_idx    out  IDX_W   table read index
//  desc_rd_data   in   DESC_W  table word, valid the cycle after desc_rd_en
//  xfer_start     out  1       1-cycle pulse: xfer_* fields valid, DMA begins (drives new_command)
//  xfer_addr      out  64      system address of current TRAN
//  xfer_len       out  17      byte count; len field 0 -> 65536
//  xfer_dir       out  1       dir bit of current TRAN
//  xfer_abort     out  1       1-cycle pulse: DMA must drop current transfer
//  xfer_done      in   1       transfer_complete from DATA/DMA
//  busy           out  1       high in any state but IDLE
//  done           out  1       1-cycle pulse: END descriptor completed
//  adma_err       out  1       sticky error, cleared by an accepted start
//  err_code       out  2       01 invalid, 10 reserved act, 11 link loop
//  cur_idx        out  IDX_W   index of descriptor being processed
// BEHAVIOUR
//  Reset: state IDLE; every output 0; internal link counter 0.
//  act = {act2,act1}: 00 NOP, 01 RSV, 10 TRAN, 11 LINK.
//  IDLE: start -> cur_idx<=start_idx, link_cnt<=0, clear adma_err/err_code, go FETCH.
//  FETCH: desc_rd_en=1, desc_rd_idx=cur_idx, go WAIT_RD; 1 cycle.
//  WAIT_RD: capture desc_rd_data into desc_q, go DECODE.
//  DECODE, by priority:
//   valid=0 -> ERR, code 01.
//   RSV     -> ERR, code 10.
//   NOP     -> if end: done pulse, IDLE; else cur_idx+1, FETCH.
//   LINK    -> if link_cnt==MAX_LINK: ERR, code 11; else cur_idx<=addr[IDX_W-1:0], link_cnt+1, FETCH.
//             END on a LINK is ignored.
//   TRAN    -> load xfer_addr/len/dir, pulse xfer_start, go WAIT_DONE.
//  WAIT_DONE: on xfer_done: if end, done pulse and IDLE; else cur_idx+1, FETCH.
//   xfer_done outside WAIT_DONE is ignored.
//  ERR: adma_err=1, err_code held, go IDLE next cycle; flag stays until the next accepted start.
//  Latencies:
//   start -> first xfer_start: 4 cycles (FETCH, WAIT_RD, DECODE, pulse registered at DECODE exit).
//   xfer_done -> next xfer_start: 4 cycles.
//  cur_idx+1 wraps modulo 2**IDX_W; no error on wrap.
//  stop_req in any busy state -> IDLE next cycle, no done.
//   If the state was WAIT_DONE, also pulse xfer_abort.
//   stop_req with xfer_done in the same cycle: stop wins, no done.
//   stop_req and start in the same cycle while IDLE: start accepted, stop ignored.
//  xfer_* fields hold their last value until the next TRAN is loaded.
//  Async reset mid-run: immediate IDLE, outputs 0, no abort pulse.
// STRUCTURE
//  Shared package sd_host_pkg:
//   act encodings (ACT_NOP/RSV/TRAN/LINK), descriptor field bit positions, err codes,
//   state enum (IDLE, FETCH, WAIT_RD, DECODE, WAIT_DONE, ERR).
//  Sub-module sd_desc_decode: combinational field extract, length 0->65536, act classify.
//  The FSM, index counter and link counter stay in this module.
// TESTING
//  T1: desc0 TRAN addr=0x1000 len=0x200 dir=0 end=1; start idx0
//      -> xfer_start 4 cycles later, len=512; xfer_done -> done pulse, busy=0.
//  T2: idx0 TRAN, idx1 NOP, idx2 TRAN end
//      -> exactly two xfer_start; second has idx2 fields; done after second xfer_done.
//  T3: idx0 LINK addr=5, idx5 TRAN len=0 end
//      -> desc_rd_idx sequence 0,5; xfer_len=65536.
//  T4: idx3 valid=0 -> adma_err=1, err_code=01, no xfer_start.
//      idx0 LINK->0 -> err_code=11 after 65 reads.
//  T5: stop_req during WAIT_DONE, same cycle as xfer_done -> xfer_abort pulse, IDLE, no done.
//  T6: start_idx=63, idx63 TRAN no end, idx0 TRAN end -> read index wraps 63->0; done after 2 xfers.
//      Reset asserted mid-WAIT_DONE -> all outputs 0.

Source files
------------

// File: rtl/sd_host_pkg.sv
// Shared SD host definitions: descriptor field layout, action encodings,
// error codes and the descriptor scheduler state set.
package sd_host_pkg;

    localparam int ADDR_MSB  = 85;
    localparam int ADDR_LSB  = 22;
    localparam int BIT_RSVD  = 21;
    localparam int LEN_MSB   = 20;
    localparam int LEN_LSB   = 5;
    localparam int BIT_ACT1  = 4;
    localparam int BIT_ACT2  = 3;
    localparam int BIT_END   = 2;
    localparam int BIT_VALID = 1;
    localparam int BIT_DIR   = 0;

    typedef enum logic [1:0] {
        ACT_NOP  = 2'b00,
        ACT_RSV  = 2'b01,
        ACT_TRAN = 2'b10,
        ACT_LINK = 2'b11
    } act_e;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_INVALID   = 2'b01;
    localparam logic [1:0] ERR_RSV_ACT   = 2'b10;
    localparam logic [1:0] ERR_LINK_LOOP = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_RD   = 3'd2,
        ST_DECODE    = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_ERR       = 3'd5
    } state_e;

endpackage

// File: rtl/sd_desc_decode.sv
// Combinational field extraction for one ADMA2 descriptor word: address,
// length (a zero length field means 65536 bytes), flags and action class.
module sd_desc_decode
    import sd_host_pkg::*;
#(
    parameter int DESC_W = 86
) (
    input  logic [DESC_W-1:0] desc,
    output logic [63:0]       addr,
    output logic [16:0]       len,
    output logic              dir,
    output logic              last,
    output logic              valid,
    output logic [1:0]        act
);

    logic [15:0] len_field_s;
    logic        unused_rsvd_s;

    assign addr          = desc[ADDR_MSB:ADDR_LSB];
    assign len_field_s   = desc[LEN_MSB:LEN_LSB];
    assign len           = (len_field_s == 16'd0) ? 17'd65536 : {1'b0, len_field_s};
    assign dir           = desc[BIT_DIR];
    assign last          = desc[BIT_END];
    assign valid         = desc[BIT_VALID];
    assign act           = {desc[BIT_ACT2], desc[BIT_ACT1]};
    assign unused_rsvd_s = desc[BIT_RSVD];

endmodule

// File: rtl/sd_adma_desc_sched.sv
// ADMA2 descriptor walker: fetches NOP/RSV/TRAN/LINK entries through a
// one-cycle read port and hands one transfer at a time to the DMA engine.
module sd_adma_desc_sched
    import sd_host_pkg::*;
#(
    parameter int DESC_W   = 86,
    parameter int IDX_W    = 6,
    parameter int MAX_LINK = 64
) (
    input  logic              clk_host,
    input  logic              reset_host,
    input  logic              start,
    input  logic [IDX_W-1:0]  start_idx,
    input  logic              stop_req,
    output logic              desc_rd_en,
    output logic [IDX_W-1:0]  desc_rd_idx,
    input  logic [DESC_W-1:0] desc_rd_data,
    output logic              xfer_start,
    output logic [63:0]       xfer_addr,
    output logic [16:0]       xfer_len,
    output logic              xfer_dir,
    output logic              xfer_abort,
    input  logic              xfer_done,
    output logic              busy,
    output logic              done,
    output logic              adma_err,
    output logic [1:0]        err_code,
    output logic [IDX_W-1:0]  cur_idx
);

    localparam int LINK_W = $clog2(MAX_LINK + 1);

    state_e             state_r;
    logic [DESC_W-1:0]  desc_q_r;
    logic [IDX_W-1:0]   cur_idx_r;
    logic [LINK_W-1:0]  link_cnt_r;
    logic               desc_rd_en_r;
    logic [IDX_W-1:0]   desc_rd_idx_r;
    logic               xfer_start_r;
    logic [63:0]        xfer_addr_r;
    logic [16:0]        xfer_len_r;
    logic               xfer_dir_r;
    logic               xfer_abort_r;
    logic               busy_r;
    logic               done_r;
    logic               adma_err_r;
    logic [1:0]         err_code_r;

    logic [63:0]        dec_addr_s;
    logic [16:0]        dec_len_s;
    logic               dec_dir_s;
    logic               dec_last_s;
    logic               dec_valid_s;
    logic [1:0]         dec_act_s;

    sd_desc_decode #(
        .DESC_W (DESC_W)
    ) u_decode (
        .desc  (desc_q_r),
        .addr  (dec_addr_s),
        .len   (dec_len_s),
        .dir   (dec_dir_s),
        .last  (dec_last_s),
        .valid (dec_valid_s),
        .act   (dec_act_s)
    );

    // Scheduler FSM with index/link counters; read strobe is issued on entry to FETCH.
    always_ff @(posedge clk_host or posedge reset_host) begin
        if (reset_host) begin
            state_r       <= ST_IDLE;
            desc_q_r      <= '0;
            cur_idx_r     <= '0;
            link_cnt_r    <= '0;
            desc_rd_en_r  <= 1'b0;
            desc_rd_idx_r <= '0;
            xfer_start_r  <= 1'b0;
            xfer_addr_r   <= 64'd0;
            xfer_len_r    <= 17'd0;
            xfer_dir_r    <= 1'b0;
            xfer_abort_r  <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            adma_err_r    <= 1'b0;
            err_code_r    <= ERR_NONE;
        end else begin
            desc_rd_en_r <= 1'b0;
            xfer_start_r <= 1'b0;
            xfer_abort_r <= 1'b0;
            done_r       <= 1'b0;
            if (stop_req && (state_r != ST_IDLE)) begin
                state_r      <= ST_IDLE;
                busy_r       <= 1'b0;
                xfer_abort_r <= (state_r == ST_WAIT_DONE);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            cur_idx_r     <= start_idx;
                            link_cnt_r    <= '0;
                            adma_err_r    <= 1'b0;
                            err_code_r    <= ERR_NONE;
                            desc_rd_en_r  <= 1'b1;
                            desc_rd_idx_r <= start_idx;
                            busy_r        <= 1'b1;
                            state_r       <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        state_r <= ST_WAIT_RD;
                    end
                    ST_WAIT_RD: begin
                        desc_q_r <= desc_rd_data;
                        state_r  <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        if (!dec_valid_s) begin
                            adma_err_r <= 1'b1;
                            err_code_r <= ERR_INVALID;
                            state_r    <= ST_ERR;
                        end else begin
                            case (dec_act_s)
                                ACT_RSV: begin
                                    adma_err_r <= 1'b1;
                                    err_code_r <= ERR_RSV_ACT;
                                    state_r    <= ST_ERR;
                                end
                                ACT_NOP: begin
                                    if (dec_last_s) begin
                                        done_r  <= 1'b1;
                                        busy_r  <= 1'b0;
                                        state_r <= ST_IDLE;
                                    end else begin
                                        cur_idx_r     <= cur_idx_r + IDX_W'(1);
                                        desc_rd_en_r  <= 1'b1;
                                        desc_rd_idx_r <= cur_idx_r + IDX_W'(1);
                                        state_r       <= ST_FETCH;
                                    end
                                end
                                // The END flag on a LINK entry has no effect.
                                ACT_LINK: begin
                                    if (link_cnt_r == LINK_W'(MAX_LINK)) begin
                                        adma_err_r <= 1'b1;
                                        err_code_r <= ERR_LINK_LOOP;
                                        state_r    <= ST_ERR;
                                    end else begin
                                        cur_idx_r     <= dec_addr_s[IDX_W-1:0];
                                        link_cnt_r    <= link_cnt_r + LINK_W'(1);
                                        desc_rd_en_r  <= 1'b1;
                                        desc_rd_idx_r <= dec_addr_s[IDX_W-1:0];
                                        state_r       <= ST_FETCH;
                                    end
                                end
                                ACT_TRAN: begin
                                    xfer_addr_r  <= dec_addr_s;
                                    xfer_len_r   <= dec_len_s;
                                    xfer_dir_r   <= dec_dir_s;
                                    xfer_start_r <= 1'b1;
                                    state_r      <= ST_WAIT_DONE;
                                end
                                default: begin
                                    adma_err_r <= 1'b1;
                                    err_code_r <= ERR_INVALID;
                                    state_r    <= ST_ERR;
                                end
                            endcase
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (xfer_done) begin
                            if (dec_last_s) begin
                                done_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= ST_IDLE;
                            end else begin
                                cur_idx_r     <= cur_idx_r + IDX_W'(1);
                                desc_rd_en_r  <= 1'b1;
                                desc_rd_idx_r <= cur_idx_r + IDX_W'(1);
                                state_r       <= ST_FETCH;
                            end
                        end
                    end
                    ST_ERR: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign desc_rd_en  = desc_rd_en_r;
    assign desc_rd_idx = desc_rd_idx_r;
    assign xfer_start  = xfer_start_r;
    assign xfer_addr   = xfer_addr_r;
    assign xfer_len    = xfer_len_r;
    assign xfer_dir    = xfer_dir_r;
    assign xfer_abort  = xfer_abort_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign adma_err    = adma_err_r;
    assign err_code    = err_code_r;
    assign cur_idx     = cur_idx_r;

endmodule

// File: tb/tb_sd_adma_desc_sched.sv
// Bench for sd_adma_desc_sched: directed tables plus random tables, each
// walked by a plain-loop reference model of the ADMA2 descriptor rules.
module tb_sd_adma_desc_sched;

    localparam int LIMIT = 20000;

    logic        clk_host = 1'b0;
    logic        reset_host;
    logic        start;
    logic [5:0]  start_idx;
    logic        stop_req;
    logic        desc_rd_en;
    logic [5:0]  desc_rd_idx;
    logic [85:0] desc_rd_data;
    logic        xfer_start;
    logic [63:0] xfer_addr;
    logic [16:0] xfer_len;
    logic        xfer_dir;
    logic        xfer_abort;
    logic        xfer_done;
    logic        busy;
    logic        done;
    logic        adma_err;
    logic [1:0]  err_code;
    logic [5:0]  cur_idx;

    logic [85:0] mem [0:63];
    int n_checks = 0;
    int n_errors = 0;

    // reference results
    logic [5:0] exp_rd[$];
    logic [5:0] exp_xf[$];
    int         exp_k[$];
    int         exp_done;
    logic       exp_err;
    logic [1:0] exp_code;
    bit         exp_runaway;

    // observations
    logic [5:0]  obs_rd[$];
    int          obs_xs_cyc[$];
    int          obs_dn_cyc[$];
    logic [63:0] obs_addr[$];
    logic [16:0] obs_len[$];
    logic        obs_dir[$];
    int          obs_done;
    int          obs_abort;
    logic        obs_err1;

    sd_adma_desc_sched dut (
        .clk_host     (clk_host),
        .reset_host   (reset_host),
        .start        (start),
        .start_idx    (start_idx),
        .stop_req     (stop_req),
        .desc_rd_en   (desc_rd_en),
        .desc_rd_idx  (desc_rd_idx),
        .desc_rd_data (desc_rd_data),
        .xfer_start   (xfer_start),
        .xfer_addr    (xfer_addr),
        .xfer_len     (xfer_len),
        .xfer_dir     (xfer_dir),
        .xfer_abort   (xfer_abort),
        .xfer_done    (xfer_done),
        .busy         (busy),
        .done         (done),
        .adma_err     (adma_err),
        .err_code     (err_code),
        .cur_idx      (cur_idx)
    );

    always #5 clk_host = ~clk_host;

    // descriptor table with one-cycle read latency
    always @(posedge clk_host) begin
        if (desc_rd_en) desc_rd_data <= mem[desc_rd_idx];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [85:0] mk(input logic [1:0] act, input logic [63:0] addr,
                                       input logic [15:0] len, input logic last,
                                       input logic valid, input logic dir);
        logic [85:0] d;
        d        = '0;
        d[85:22] = addr;
        d[20:5]  = len;
        d[4]     = act[0];
        d[3]     = act[1];
        d[2]     = last;
        d[1]     = valid;
        d[0]     = dir;
        return d;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    // Walk the table by the descriptor rules; k counts reads leading to each TRAN.
    task automatic model_run(input logic [5:0] sidx);
        logic [5:0]  idx;
        logic [85:0] d;
        int links;
        int k;
        bit fin;
        idx = sidx; links = 0; k = 0; fin = 0;
        exp_rd.delete(); exp_xf.delete(); exp_k.delete();
        exp_done = 0; exp_err = 1'b0; exp_code = 2'b00; exp_runaway = 0;
        while (!fin) begin
            if (exp_rd.size() >= 400) begin
                exp_runaway = 1; fin = 1;
            end else begin
                d = mem[idx];
                exp_rd.push_back(idx);
                k++;
                if (!d[1]) begin
                    exp_err = 1'b1; exp_code = 2'b01; fin = 1;
                end else if ({d[3], d[4]} == 2'b01) begin
                    exp_err = 1'b1; exp_code = 2'b10; fin = 1;
                end else if ({d[3], d[4]} == 2'b00) begin
                    if (d[2]) begin exp_done = 1; fin = 1; end
                    else idx = idx + 6'd1;
                end else if ({d[3], d[4]} == 2'b11) begin
                    if (links == 64) begin exp_err = 1'b1; exp_code = 2'b11; fin = 1; end
                    else begin idx = d[27:22]; links++; end
                end else begin
                    exp_xf.push_back(idx);
                    exp_k.push_back(k);
                    k = 0;
                    if (d[2]) begin exp_done = 1; fin = 1; end
                    else idx = idx + 6'd1;
                end
            end
        end
    endtask

    task automatic run_dut(input logic [5:0] sidx);
        int cyc;
        bit pending;
        int wait_cnt;
        cyc = 0; pending = 0; wait_cnt = 0;
        obs_rd.delete(); obs_xs_cyc.delete(); obs_dn_cyc.delete();
        obs_addr.delete(); obs_len.delete(); obs_dir.delete();
        obs_done = 0; obs_abort = 0; obs_err1 = 1'b0;
        start_idx = sidx;
        start = 1'b1;
        do begin
            @(negedge clk_host);
            cyc++;
            start = 1'b0;
            if (cyc == 1) obs_err1 = adma_err;
            if (desc_rd_en) obs_rd.push_back(desc_rd_idx);
            if (xfer_start) begin
                obs_xs_cyc.push_back(cyc);
                obs_addr.push_back(xfer_addr);
                obs_len.push_back(xfer_len);
                obs_dir.push_back(xfer_dir);
                pending = 1;
                wait_cnt = int'($urandom_range(0, 4));
            end
            if (done) obs_done++;
            if (xfer_abort) obs_abort++;
            if (pending) begin
                if (wait_cnt == 0) begin
                    xfer_done = 1'b1; pending = 0; obs_dn_cyc.push_back(cyc);
                end else begin
                    xfer_done = 1'b0; wait_cnt--;
                end
            end else begin
                xfer_done = ($urandom_range(0, 7) == 0);
            end
        end while (busy && cyc < LIMIT);
        xfer_done = 1'b0;
        check_eq("run_timeout", 64'(cyc < LIMIT), 64'd1);
    endtask

    task automatic compare_run(input string name);
        int n;
        int trig;
        logic [85:0] d;
        check_eq({name, "_reads"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
        n = (obs_rd.size() < exp_rd.size()) ? obs_rd.size() : exp_rd.size();
        for (int i = 0; i < n; i++) check_eq({name, "_rd_idx"}, 64'(obs_rd[i]), 64'(exp_rd[i]));
        check_eq({name, "_xfers"}, 64'(obs_xs_cyc.size()), 64'(exp_xf.size()));
        n = (obs_xs_cyc.size() < exp_xf.size()) ? obs_xs_cyc.size() : exp_xf.size();
        for (int i = 0; i < n; i++) begin
            d = mem[exp_xf[i]];
            check_eq({name, "_addr"}, obs_addr[i], d[85:22]);
            check_eq({name, "_len"}, 64'(obs_len[i]), (d[20:5] == 16'd0) ? 64'd65536 : 64'(d[20:5]));
            check_eq({name, "_dir"}, 64'(obs_dir[i]), 64'(d[0]));
            if (i == 0 || (i - 1) < obs_dn_cyc.size()) begin
                trig = (i == 0) ? 0 : obs_dn_cyc[i-1];
                check_eq({name, "_latency"}, 64'(obs_xs_cyc[i] - trig), 64'(3 * exp_k[i] + 1));
            end
        end
        check_eq({name, "_done"}, 64'(obs_done), 64'(exp_done));
        check_eq({name, "_abort"}, 64'(obs_abort), 64'd0);
        check_eq({name, "_adma_err"}, 64'(adma_err), 64'(exp_err));
        check_eq({name, "_err_code"}, 64'(err_code), 64'(exp_code));
        check_eq({name, "_busy"}, 64'(busy), 64'd0);
        check_eq({name, "_err_clr"}, 64'(obs_err1), 64'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_rd_en"}, 64'(desc_rd_en), 64'd0);
        check_eq({tag, "_rd_idx"}, 64'(desc_rd_idx), 64'd0);
        check_eq({tag, "_xstart"}, 64'(xfer_start), 64'd0);
        check_eq({tag, "_xaddr"}, xfer_addr, 64'd0);
        check_eq({tag, "_xlen"}, 64'(xfer_len), 64'd0);
        check_eq({tag, "_xdir"}, 64'(xfer_dir), 64'd0);
        check_eq({tag, "_abort"}, 64'(xfer_abort), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_err"}, 64'(adma_err), 64'd0);
        check_eq({tag, "_code"}, 64'(err_code), 64'd0);
        check_eq({tag, "_cur"}, 64'(cur_idx), 64'd0);
    endtask

    task automatic wait_xfer_start(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk_host);
            start = 1'b0;
            if (xfer_start) seen = 1;
        end
        check_eq({tag, "_xfer_start_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic gen_table();
        int r;
        logic [1:0] act;
        logic [85:0] d;
        for (int i = 0; i < 64; i++) begin
            r = int'($urandom_range(0, 99));
            act = (r < 50) ? 2'b10 : (r < 80) ? 2'b00 : (r < 95) ? 2'b11 : 2'b01;
            d = mk(act, {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 29) != 0), 1'($urandom));
            d[21] = 1'($urandom);
            mem[i] = d;
        end
    endtask

    initial begin
        reset_host = 1'b1; start = 1'b0; start_idx = 6'd0; stop_req = 1'b0; xfer_done = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk_host);
        check_zero("reset");
        reset_host = 1'b0;
        @(negedge clk_host);

        // T1: single TRAN with END
        clear_mem();
        mem[0] = mk(2'b10, 64'h1000, 16'h0200, 1'b1, 1'b1, 1'b0);
        model_run(6'd0); run_dut(6'd0); compare_run("t1");
        check_eq("t1_len512", (obs_len.size() > 0) ? 64'(obs_len[0]) : 64'd0, 64'd512);
        check_eq("t1_lat4", (obs_xs_cyc.size() > 0) ? 64'(obs_xs_cyc[0]) : 64'd0, 64'd4);

        // T2: TRAN, NOP, TRAN END
        clear_mem();
        mem[0] = mk(2'b10, 64'hA000_0000_0000_0040, 16'h0010, 1'b0, 1'b1, 1'b1);
        mem[1] = mk(2'b00, 64'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        mem[2] = mk(2'b10, 64'h0000_0000_0002_2000, 16'h0800, 1'b1, 1'b1, 1'b0);
        model_run(6'd0); run_dut(6'd0); compare_run("t2");
        check_eq("t2_two_xfers", 64'(obs_xs_cyc.size()), 64'd2);

        // T3: LINK to 5, TRAN len 0
        clear_mem();
        mem[0] = mk(2'b11, 64'd5, 16'h0, 1'b0, 1'b1, 1'b0);
        mem[5] = mk(2'b10, 64'h3000, 16'h0, 1'b1, 1'b1, 1'b1);
        model_run(6'd0); run_dut(6'd0); compare_run("t3");
        check_eq("t3_len64k", (obs_len.size() > 0) ? 64'(obs_len[0]) : 64'd0, 64'd65536);

        // T4: invalid entry, then a self-LINK loop
        clear_mem();
        model_run(6'd3); run_dut(6'd3); compare_run("t4a");
        check_eq("t4a_code", 64'(err_code), 64'd1);
        mem[0] = mk(2'b11, 64'd0, 16'h0, 1'b1, 1'b1, 1'b0);
        model_run(6'd0); run_dut(6'd0); compare_run("t4b");
        check_eq("t4b_reads65", 64'(obs_rd.size()), 64'd65);
        check_eq("t4b_code", 64'(err_code), 64'd3);
        repeat (3) @(negedge clk_host);
        check_eq("t4b_sticky", 64'(adma_err), 64'd1);

        // T5: stop with xfer_done in WAIT_DONE
        clear_mem();
        mem[0] = mk(2'b10, 64'h5000, 16'h0040, 1'b1, 1'b1, 1'b0);
        start_idx = 6'd0; start = 1'b1;
        wait_xfer_start("t5");
        @(negedge clk_host);
        stop_req = 1'b1; xfer_done = 1'b1;
        @(negedge clk_host);
        stop_req = 1'b0; xfer_done = 1'b0;
        check_eq("t5_abort", 64'(xfer_abort), 64'd1);
        check_eq("t5_busy", 64'(busy), 64'd0);
        check_eq("t5_nodone", 64'(done), 64'd0);
        @(negedge clk_host);
        check_eq("t5_abort_pulse", 64'(xfer_abort), 64'd0);
        check_eq("t5_nodone2", 64'(done), 64'd0);
        // start and stop together while idle: start wins; stop in FETCH: no abort
        start = 1'b1; stop_req = 1'b1;
        @(negedge clk_host);
        start = 1'b0; stop_req = 1'b0;
        check_eq("t5_start_wins", 64'(busy), 64'd1);
        check_eq("t5_rd_en", 64'(desc_rd_en), 64'd1);
        stop_req = 1'b1;
        @(negedge clk_host);
        stop_req = 1'b0;
        check_eq("t5_fetch_stop_busy", 64'(busy), 64'd0);
        check_eq("t5_fetch_stop_abort", 64'(xfer_abort), 64'd0);

        // T6: index wrap 63 -> 0
        clear_mem();
        mem[63] = mk(2'b10, 64'h6300, 16'h0100, 1'b0, 1'b1, 1'b1);
        mem[0]  = mk(2'b10, 64'h0600, 16'h0200, 1'b1, 1'b1, 1'b0);
        model_run(6'd63); run_dut(6'd63); compare_run("t6");
        check_eq("t6_wrap_idx", (obs_rd.size() > 1) ? 64'(obs_rd[1]) : 64'hFF, 64'd0);

        // reset in WAIT_DONE
        start_idx = 6'd63; start = 1'b1;
        wait_xfer_start("t6r");
        #2 reset_host = 1'b1;
        #1 check_zero("midreset");
        @(negedge clk_host);
        reset_host = 1'b0;
        @(negedge clk_host);
        check_eq("midreset_noabort", 64'(xfer_abort), 64'd0);
        check_eq("midreset_idle", 64'(busy), 64'd0);

        // random tables
        for (int t = 0; t < 25; t++) begin
            logic [5:0] sidx;
            int tries;
            tries = 0;
            do begin
                gen_table();
                sidx = 6'($urandom);
                model_run(sidx);
                tries++;
            end while (exp_runaway && tries < 50);
            if (!exp_runaway) begin
                run_dut(sidx);
                compare_run("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
